// File: rtl/lcd_frame_capture.sv
// lcd_frame_capture: rebuilds x/y from the PPU display strobes, maps colour
// indices through the BGP palette and writes shades into the back bank of a
// double-buffered frame RAM. Banks swap only after a complete, clean frame.
module lcd_frame_capture #(
    parameter int H_PIXELS = 160,
    parameter int V_LINES  = 144,
    parameter int ADDR_W   = 15
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              lcd_hsync,
    input  logic              lcd_vsync,
    input  logic              lcd_pixel,
    input  logic [1:0]        lcd_color,
    input  logic [7:0]        bgp,
    output logic              fb_wr_en,
    output logic [ADDR_W:0]   fb_wr_addr,
    output logic [1:0]        fb_wr_data,
    output logic              front_bank,
    output logic              frame_done,
    output logic              line_err,
    output logic              frame_err
);

    localparam logic [1:0] WAIT_SYNC = 2'd0;
    localparam logic [1:0] ACTIVE    = 2'd1;
    localparam logic [1:0] VBLANK    = 2'd2;

    localparam logic [7:0]        H_MAX  = 8'(H_PIXELS);
    localparam logic [7:0]        V_MAX  = 8'(V_LINES);
    localparam logic [ADDR_W-1:0] H_STEP = ADDR_W'(H_PIXELS);

    logic [1:0]        state;
    logic [7:0]        x;
    logic [7:0]        y;
    logic [ADDR_W-1:0] line_base;
    logic              hs_q;
    logic              vs_q;
    logic              frame_bad;

    logic              hs_rise;
    logic              vs_rise;
    logic              vs_fall;
    logic              pix_ok;
    logic              line_end;
    logic              frame_end;
    logic [7:0]        x_inc;
    logic [7:0]        y_after;
    logic              line_bad;
    logic              bad_after;
    logic              frame_good;
    logic [1:0]        shade;

    // Sync edge detection, pixel qualification and palette lookup.
    always_comb begin
        hs_rise   = lcd_hsync & ~hs_q;
        vs_rise   = lcd_vsync & ~vs_q;
        vs_fall   = ~lcd_vsync & vs_q;
        pix_ok    = lcd_pixel & ~lcd_hsync & ~lcd_vsync & (state == ACTIVE);
        line_end  = hs_rise & (state == ACTIVE);
        frame_end = vs_rise & (state == ACTIVE);
        shade     = bgp[{lcd_color, 1'b0} +: 2];
    end

    // Next-value terms; a line end coinciding with frame end is folded in
    // first so the frame check sees the updated y and error flag.
    always_comb begin
        x_inc      = (x == 8'hFF) ? x : x + 8'd1;
        y_after    = y;
        if (line_end && (y != 8'hFF)) begin
            y_after = y + 8'd1;
        end
        line_bad   = line_end && (x != H_MAX);
        bad_after  = frame_bad | line_bad;
        frame_good = (y_after == V_MAX) && !bad_after && !line_err;
    end

    // Capture state machine, position counters and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_SYNC;
            x          <= '0;
            y          <= '0;
            line_base  <= '0;
            hs_q       <= 1'b0;
            vs_q       <= 1'b0;
            frame_bad  <= 1'b0;
            fb_wr_en   <= 1'b0;
            fb_wr_addr <= '0;
            fb_wr_data <= '0;
            front_bank <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            hs_q       <= lcd_hsync;
            vs_q       <= lcd_vsync;
            fb_wr_en   <= 1'b0;
            frame_done <= 1'b0;
            line_err   <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                WAIT_SYNC, VBLANK: begin
                    if (vs_fall) begin
                        state     <= ACTIVE;
                        x         <= '0;
                        y         <= '0;
                        line_base <= '0;
                        frame_bad <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (pix_ok) begin
                        x <= x_inc;
                        if ((x < H_MAX) && (y < V_MAX)) begin
                            fb_wr_en   <= 1'b1;
                            fb_wr_addr <= {~front_bank, line_base + ADDR_W'(x)};
                            fb_wr_data <= shade;
                        end
                    end
                    if (line_end) begin
                        x         <= '0;
                        y         <= y_after;
                        line_err  <= line_bad;
                        frame_bad <= bad_after;
                        if (y < V_MAX) begin
                            line_base <= line_base + H_STEP;
                        end
                    end
                    if (frame_end) begin
                        state <= VBLANK;
                        if (frame_good) begin
                            front_bank <= ~front_bank;
                            frame_done <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end
                end
                default: state <= WAIT_SYNC;
            endcase
        end
    end

endmodule

// File: tb/tb_lcd_frame_capture.sv
// Bench for lcd_frame_capture: directed frames, a queue of expected writes
// built from the frame geometry and palette, and per-frame pulse checks.
module tb_lcd_frame_capture;

    logic        clk = 1'b0;
    logic        rst;
    logic        lcd_hsync;
    logic        lcd_vsync;
    logic        lcd_pixel;
    logic [1:0]  lcd_color;
    logic [7:0]  bgp;
    logic        fb_wr_en;
    logic [15:0] fb_wr_addr;
    logic [1:0]  fb_wr_data;
    logic        front_bank;
    logic        frame_done;
    logic        line_err;
    logic        frame_err;

    lcd_frame_capture #(.H_PIXELS(160), .V_LINES(144), .ADDR_W(15)) dut (
        .clk(clk), .rst(rst),
        .lcd_hsync(lcd_hsync), .lcd_vsync(lcd_vsync),
        .lcd_pixel(lcd_pixel), .lcd_color(lcd_color), .bgp(bgp),
        .fb_wr_en(fb_wr_en), .fb_wr_addr(fb_wr_addr), .fb_wr_data(fb_wr_data),
        .front_bank(front_bank), .frame_done(frame_done),
        .line_err(line_err), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [17:0] exp_q[$];
    logic [17:0] exp_e;
    int          wr_cnt;
    logic [15:0] last_addr;
    logic [1:0]  last_data;
    int          cnt_done;
    int          cnt_ferr;
    int          cnt_lerr;
    bit          mf;          // model front bank
    int          line_len[144];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Compare every DUT write against the expected queue; tally pulses.
    always @(negedge clk) begin
        if (fb_wr_en === 1'b1) begin
            wr_cnt++;
            last_addr = fb_wr_addr;
            last_data = fb_wr_data;
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_write: got addr=%h data=%0d expected no write", fb_wr_addr, fb_wr_data);
            end else begin
                exp_e = exp_q.pop_front();
                if ({fb_wr_addr, fb_wr_data} !== exp_e) begin
                    n_fail++;
                    $display("FAIL write: got addr=%h data=%0d expected addr=%h data=%0d",
                             fb_wr_addr, fb_wr_data, exp_e[17:2], exp_e[1:0]);
                end
            end
        end
        if (frame_done === 1'b1) cnt_done++;
        if (frame_err === 1'b1) cnt_ferr++;
        if (line_err === 1'b1) cnt_lerr++;
    end

    // Drive one frame of nlines lines; optionally pulse rst at the start of rst_line.
    task automatic run_frame(input int nlines, input bit pre_vs, input bit active,
                             input int rst_line, input logic [7:0] pal);
        bit good;
        int exp_le;
        bgp      = pal;
        wr_cnt   = 0;
        cnt_done = 0;
        cnt_ferr = 0;
        cnt_lerr = 0;
        if (pre_vs) begin
            lcd_vsync = 1'b1;
            repeat (10) tick();
        end
        lcd_vsync = 1'b0;
        tick();
        for (int l = 0; l < nlines; l++) begin
            if (l == rst_line) begin
                rst = 1'b1;
                tick();
                tick();
                check("reset_front_bank", {31'd0, front_bank}, 32'd0);
                rst    = 1'b0;
                active = 1'b0;
                mf     = 1'b0;
            end
            for (int p = 0; p < line_len[l]; p++) begin
                lcd_pixel = 1'b1;
                lcd_color = 2'(p);
                if (active && p < 160 && l < 144)
                    exp_q.push_back({~mf, 15'(l * 160 + p), 2'((pal >> (2 * (p % 4))) & 8'd3)});
                tick();
            end
            lcd_pixel = 1'b0;
            lcd_hsync = 1'b1;
            tick();
            lcd_hsync = 1'b0;
            tick();
        end
        good   = active && (nlines == 144);
        exp_le = 0;
        for (int l = 0; l < nlines; l++) begin
            if (line_len[l] != 160) begin
                good = 1'b0;
                if (active) exp_le++;
            end
        end
        lcd_vsync = 1'b1;
        repeat (3) tick();
        if (good) mf = ~mf;
        check("queue_drained", exp_q.size(), 0);
        check("frame_done_cnt", cnt_done, good ? 1 : 0);
        check("frame_err_cnt", cnt_ferr, (active && !good) ? 1 : 0);
        check("line_err_cnt", cnt_lerr, exp_le);
        check("front_bank", {31'd0, front_bank}, {31'd0, mf});
    endtask

    initial begin
        rst       = 1'b1;
        lcd_hsync = 1'b0;
        lcd_vsync = 1'b0;
        lcd_pixel = 1'b0;
        lcd_color = 2'd0;
        bgp       = 8'hE4;
        mf        = 1'b0;
        for (int l = 0; l < 144; l++) line_len[l] = 160;
        repeat (3) tick();
        check("rst_fb_wr_en", {31'd0, fb_wr_en}, 0);
        check("rst_fb_wr_addr", {16'd0, fb_wr_addr}, 0);
        check("rst_fb_wr_data", {30'd0, fb_wr_data}, 0);
        check("rst_front_bank", {31'd0, front_bank}, 0);
        check("rst_frame_done", {31'd0, frame_done}, 0);
        check("rst_line_err", {31'd0, line_err}, 0);
        check("rst_frame_err", {31'd0, frame_err}, 0);
        rst = 1'b0;
        tick();

        // Pixels with no vsync pulse since reset: nothing may happen.
        run_frame(3, 1'b0, 1'b0, -1, 8'hE4);
        check("nosync_writes", wr_cnt, 0);

        // Full frame, identity palette.
        run_frame(144, 1'b1, 1'b1, -1, 8'hE4);
        check("f1_writes", wr_cnt, 23040);
        check("f1_last_addr", {16'd0, last_addr}, 32'h0000_D9FF);
        check("f1_last_data", {30'd0, last_data}, 3);
        check("f1_front", {31'd0, front_bank}, 1);

        // Reset at line 60; rest of frame ignored.
        run_frame(62, 1'b1, 1'b1, 60, 8'hE4);
        check("rst_frame_writes", wr_cnt, 9600);
        check("rst_frame_front", {31'd0, front_bank}, 0);

        // Next full frame after reset completes normally.
        run_frame(144, 1'b1, 1'b1, -1, 8'hE4);
        check("f2_done", cnt_done, 1);
        check("f2_last_addr", {16'd0, last_addr}, 32'h0000_D9FF);
        check("f2_front", {31'd0, front_bank}, 1);

        // Short line 5, long line 7, frame cut after line 8.
        line_len[5] = 159;
        line_len[7] = 165;
        run_frame(9, 1'b1, 1'b1, -1, 8'hE4);
        check("bad_line_errs", cnt_lerr, 2);
        check("bad_frame_err", cnt_ferr, 1);
        check("bad_frame_done", cnt_done, 0);
        check("bad_writes", wr_cnt, 1439);
        check("bad_last_addr", {16'd0, last_addr}, 32'h0000_059F);
        check("bad_front", {31'd0, front_bank}, 1);
        line_len[5] = 160;
        line_len[7] = 160;

        // Inverted palette; writes the same bank the failed frame used.
        run_frame(144, 1'b1, 1'b1, -1, 8'h1B);
        check("f3_last_addr", {16'd0, last_addr}, 32'h0000_59FF);
        check("f3_last_data", {30'd0, last_data}, 0);
        check("f3_front", {31'd0, front_bank}, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
